ts_rec_ctrl: RTL and testbench

Record/playback sequencer for the MPEG-TS recorder. It takes the one-cycle button-release pulses from the button release detector and drives a single-port byte buffer through three modes: record incoming TS bytes, play them back, or idle. It generates the buffer address, write and read strobes, and tracks recorded length and full status. Mode and status outputs are also driven to board LEDs.

---
 rtl/ts_rec_ctrl.sv | 132 +++++++++++++
 tb/tb_ts_rec_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_rec_ctrl.sv
// Record/playback sequencer for the MPEG-TS recorder: turns button-release pulses
// into REC/PLAY/IDLE modes and drives address and strobes for a single-port byte buffer.
module ts_rec_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [3:0]        RELEASE,
  input  logic              IN_VALID,
  input  logic              OUT_READY,
  output logic              MEM_WE,
  output logic              MEM_RE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              OUT_VALID,
  output logic [ADDR_W:0]   REC_LEN,
  output logic [1:0]        STATE,
  output logic              FULL,
  output logic              DONE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REC  = 2'b01,
    ST_PLAY = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ONE     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ZERO    = '0;
  localparam logic [ADDR_W:0]   LEN_LAST_WR = {1'b0, {ADDR_W{1'b1}}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     rec_len_q, rec_len_d;
  logic                out_valid_q;
  logic                done_q, done_d;

  logic                full;
  logic                we;
  logic                re;
  logic                last_rd;
  logic                stop_rel, rec_rel, play_rel, clear_rel;

  // Fixed priority STOP > REC > PLAY > CLEAR: only the winning bit is seen below.
  assign stop_rel  = RELEASE[1];
  assign rec_rel   = RELEASE[0] & ~RELEASE[1];
  assign play_rel  = RELEASE[2] & ~RELEASE[1] & ~RELEASE[0];
  assign clear_rel = RELEASE[3] & ~(|RELEASE[2:0]);

  // Capacity is exactly 2^ADDR_W, so the length MSB alone marks a full buffer.
  assign full    = rec_len_q[ADDR_W];
  assign we      = (state_q == ST_REC) & IN_VALID & ~full;
  assign re      = (state_q == ST_PLAY) & OUT_READY;
  assign last_rd = ({1'b0, rd_ptr_q} == (rec_len_q - LEN_ONE));

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rec_len_d = rec_len_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rec_rel) begin
          state_d   = ST_REC;
          wr_ptr_d  = '0;
          rec_len_d = LEN_ZERO;
        end else if (play_rel && (rec_len_q != LEN_ZERO)) begin
          state_d  = ST_PLAY;
          rd_ptr_d = '0;
        end else if (clear_rel) begin
          rec_len_d = LEN_ZERO;
        end
      end

      ST_REC: begin
        if (we) begin
          wr_ptr_d  = wr_ptr_q + PTR_ONE;
          rec_len_d = rec_len_q + LEN_ONE;
        end
        if ((we && (rec_len_q == LEN_LAST_WR)) || stop_rel) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      ST_PLAY: begin
        if (re) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if ((re && last_rd) || stop_rel) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rec_len_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rec_len_q   <= rec_len_d;
      out_valid_q <= re;
      done_q      <= done_d;
    end
  end

  assign MEM_WE    = we;
  assign MEM_RE    = re;
  assign MEM_ADDR  = (state_q == ST_REC) ? wr_ptr_q : rd_ptr_q;
  assign OUT_VALID = out_valid_q;
  assign REC_LEN   = rec_len_q;
  assign STATE     = state_q;
  assign FULL      = full;
  assign DONE      = done_q;

endmodule

// File: tb/tb_ts_rec_ctrl.sv
// Self-checking bench for ts_rec_ctrl with an 8-byte buffer: directed scenarios
// followed by randomized stimulus against a behavioural model.
module tb_ts_rec_ctrl;
  localparam int AW  = 3;
  localparam int CAP = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    rel;
  logic          iv;
  logic          ordy;
  logic          MEM_WE, MEM_RE, OUT_VALID, FULL, DONE;
  logic [AW-1:0] MEM_ADDR;
  logic [AW:0]   REC_LEN;
  logic [1:0]    STATE;

  int checks = 0;
  int errors = 0;
  int we_log[$];
  int re_log[$];
  int done_cnt = 0;

  ts_rec_ctrl #(.ADDR_W(AW)) dut (
    .CLOCK(clk), .RESET(rst), .RELEASE(rel), .IN_VALID(iv), .OUT_READY(ordy),
    .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_ADDR(MEM_ADDR), .OUT_VALID(OUT_VALID),
    .REC_LEN(REC_LEN), .STATE(STATE), .FULL(FULL), .DONE(DONE)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (MEM_WE === 1'b1) we_log.push_back(int'(MEM_ADDR));
    if (MEM_RE === 1'b1) re_log.push_back(int'(MEM_ADDR));
    if (DONE === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic v, input logic o);
    rel = r; iv = v; ordy = o;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive(4'b0000, 1'b0, 1'b0);
    tick(); tick();
    checks++; if (STATE !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", STATE); end
    checks++; if (REC_LEN !== 4'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", REC_LEN); end
    checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", FULL); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b want 0", OUT_VALID); end
    checks++; if (MEM_ADDR !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", MEM_ADDR); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_record_stop();
    int d0;
    bit ok;
    we_log.delete(); d0 = done_cnt;
    drive(4'b0001, 1'b0, 1'b0); tick();
    checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL rec_enter: got %b want 01", STATE); end
    for (int i = 0; i < 5; i++) begin
      drive(4'b0000, 1'b1, 1'b0); #1;
      checks++; if (MEM_WE !== 1'b1 || MEM_ADDR !== 3'(i)) begin
        errors++; $display("FAIL rec_write: got we=%b addr=%0d want we=1 addr=%0d", MEM_WE, MEM_ADDR, i);
      end
      tick();
    end
    drive(4'b0010, 1'b0, 1'b0); tick(); drive(4'b0000, 1'b0, 1'b0);
    checks++; if (STATE !== 2'b00) begin errors++; $display("FAIL rec_stop_state: got %b want 00", STATE); end
    checks++; if (REC_LEN !== 4'd5) begin errors++; $display("FAIL rec_stop_len: got %0d want 5", REC_LEN); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL rec_stop_done: got %b want 1", DONE); end
    checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL rec_stop_full: got %b want 0", FULL); end
    tick();
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rec_done_width: got %b want 0", DONE); end
    ok = (we_log.size() == 5);
    for (int i = 0; i < we_log.size() && ok; i++) if (we_log[i] != i) ok = 0;
    checks++; if (!ok) begin errors++; $display("FAIL rec_addr_seq: got %0d writes want 5 at 0..4", we_log.size()); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rec_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_play_throttle();
    int d0;
    int reads;
    bit timeout;
    bit ok;
    logic o;
    re_log.delete(); d0 = done_cnt; reads = 0; timeout = 1;
    drive(4'b0100, 1'b0, 1'b0); tick();
    checks++; if (STATE !== 2'b10) begin errors++; $display("FAIL play_enter: got %b want 10", STATE); end
    for (int i = 0; i < 20; i++) begin
      o = (i % 2 == 0);
      drive(4'b0000, 1'b0, o); #1;
      checks++; if (MEM_RE !== o) begin errors++; $display("FAIL play_re: got %b want %b", MEM_RE, o); end
      if (o) begin
        checks++; if (MEM_ADDR !== 3'(reads)) begin errors++; $display("FAIL play_addr: got %0d want %0d", MEM_ADDR, reads); end
      end
      tick();
      checks++; if (OUT_VALID !== o) begin errors++; $display("FAIL play_ov: got %b want %b", OUT_VALID, o); end
      if (o) reads++;
      if (STATE === 2'b00) begin timeout = 0; break; end
    end
    checks++; if (timeout) begin errors++; $display("FAIL play_timeout: got state %b want 00 within 20 cycles", STATE); end
    checks++; if (reads != 5) begin errors++; $display("FAIL play_reads: got %0d want 5", reads); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL play_done: got %b want 1", DONE); end
    drive(4'b0000, 1'b0, 1'b0); tick();
    checks++; if (OUT_VALID !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("FAIL play_after: got ov=%b done=%b want 0 0", OUT_VALID, DONE);
    end
    ok = (re_log.size() == 5);
    for (int i = 0; i < re_log.size() && ok; i++) if (re_log[i] != i) ok = 0;
    checks++; if (!ok) begin errors++; $display("FAIL play_addr_seq: got %0d reads want 5 at 0..4", re_log.size()); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL play_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_fill();
    int d0;
    bit ok;
    logic exp_we;
    we_log.delete(); d0 = done_cnt;
    drive(4'b0001, 1'b0, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      exp_we = (i < 8);
      drive(4'b0000, 1'b1, 1'b0); #1;
      checks++; if (MEM_WE !== exp_we) begin errors++; $display("FAIL fill_we%0d: got %b want %b", i, MEM_WE, exp_we); end
      tick();
      if (i == 7) begin
        checks++; if (STATE !== 2'b00) begin errors++; $display("FAIL fill_state: got %b want 00", STATE); end
        checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", FULL); end
        checks++; if (REC_LEN !== 4'd8) begin errors++; $display("FAIL fill_len: got %0d want 8", REC_LEN); end
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL fill_done: got %b want 1", DONE); end
      end
    end
    drive(4'b0000, 1'b0, 1'b0); tick();
    ok = (we_log.size() == 8);
    for (int i = 0; i < we_log.size() && ok; i++) if (we_log[i] != i) ok = 0;
    checks++; if (!ok) begin errors++; $display("FAIL fill_addr_seq: got %0d writes want 8 at 0..7", we_log.size()); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL fill_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL fill_full_hold: got %b want 1", FULL); end
  endtask

  task automatic test_empty_priority();
    drive(4'b1000, 1'b0, 1'b0); tick();
    checks++; if (REC_LEN !== 4'd0 || FULL !== 1'b0) begin
      errors++; $display("FAIL clear: got len=%0d full=%b want 0 0", REC_LEN, FULL);
    end
    drive(4'b0100, 1'b0, 1'b1); tick();
    drive(4'b0000, 1'b0, 1'b1); #1;
    checks++; if (STATE !== 2'b00 || MEM_RE !== 1'b0) begin
      errors++; $display("FAIL empty_play: got state=%b re=%b want 00 0", STATE, MEM_RE);
    end
    tick();
    drive(4'b0101, 1'b0, 1'b0); tick();
    checks++; if (STATE !== 2'b01) begin errors++; $display("FAIL prio_rec_play: got %b want 01", STATE); end
    drive(4'b0010, 1'b0, 1'b0); tick();
    checks++; if (STATE !== 2'b00 || DONE !== 1'b1 || REC_LEN !== 4'd0) begin
      errors++; $display("FAIL prio_stop_rec: got state=%b done=%b len=%0d want 00 1 0", STATE, DONE, REC_LEN);
    end
    drive(4'b0011, 1'b0, 1'b0); tick();
    checks++; if (STATE !== 2'b00) begin errors++; $display("FAIL prio_stop_wins: got %b want 00", STATE); end
    drive(4'b0000, 1'b0, 1'b0); tick();
  endtask

  task automatic test_reset_mid();
    drive(4'b0001, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin drive(4'b0000, 1'b1, 1'b0); tick(); end
    checks++; if (REC_LEN !== 4'd3) begin errors++; $display("FAIL rmid_len_pre: got %0d want 3", REC_LEN); end
    rst = 1'b1; drive(4'b0000, 1'b0, 1'b0); tick(); rst = 1'b0;
    checks++; if (STATE !== 2'b00 || REC_LEN !== 4'd0 || MEM_ADDR !== 3'd0 || DONE !== 1'b0) begin
      errors++; $display("FAIL rmid: got state=%b len=%0d addr=%0d done=%b want 00 0 0 0", STATE, REC_LEN, MEM_ADDR, DONE);
    end
    drive(4'b0100, 1'b0, 1'b1); tick(); drive(4'b0000, 1'b0, 1'b0);
    checks++; if (STATE !== 2'b00) begin errors++; $display("FAIL rmid_play: got %b want 00", STATE); end
    tick();
  endtask

  task automatic test_stop_write();
    drive(4'b0001, 1'b0, 1'b0); tick();
    for (int i = 0; i < 2; i++) begin drive(4'b0000, 1'b1, 1'b0); tick(); end
    drive(4'b0010, 1'b1, 1'b0); #1;
    checks++; if (MEM_WE !== 1'b1 || MEM_ADDR !== 3'd2) begin
      errors++; $display("FAIL stopw_we: got we=%b addr=%0d want 1 2", MEM_WE, MEM_ADDR);
    end
    tick(); drive(4'b0000, 1'b0, 1'b0);
    checks++; if (REC_LEN !== 4'd3 || STATE !== 2'b00 || DONE !== 1'b1) begin
      errors++; $display("FAIL stopw: got len=%0d state=%b done=%b want 3 00 1", REC_LEN, STATE, DONE);
    end
    tick();
  endtask

  // Model: mode 0 idle, 1 recording, 2 playing; positions and length as plain integers.
  task automatic test_random();
    int mode, wp, rp, len;
    bit ov, dn, stop, recw, playw, clrw, fin;
    bit exp_we, exp_re;
    int exp_addr;
    rst = 1'b1; drive(4'b0000, 1'b0, 1'b0); tick(); rst = 1'b0;
    mode = 0; wp = 0; rp = 0; len = 0; ov = 0; dn = 0;
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 99) < 8) ? 4'($urandom_range(1, 15)) : 4'b0000,
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      #1;
      exp_we   = (mode == 1) && iv && (len < CAP);
      exp_re   = (mode == 2) && ordy;
      exp_addr = (mode == 1) ? wp : rp;
      checks++; if (MEM_WE !== exp_we || MEM_RE !== exp_re || MEM_ADDR !== 3'(exp_addr)) begin
        errors++; $display("FAIL rnd_strobe c%0d: got we=%b re=%b addr=%0d want %b %b %0d",
                           c, MEM_WE, MEM_RE, MEM_ADDR, exp_we, exp_re, exp_addr);
      end
      tick();
      if (rst) begin
        mode = 0; wp = 0; rp = 0; len = 0; ov = 0; dn = 0;
      end else begin
        ov = exp_re; dn = 0; fin = 0;
        stop  = rel[1];
        recw  = !rel[1] && rel[0];
        playw = !rel[1] && !rel[0] && rel[2];
        clrw  = rel[3] && (rel[2:0] == 3'b000);
        if (mode == 0) begin
          if (recw) begin mode = 1; wp = 0; len = 0; end
          else if (playw && len != 0) begin mode = 2; rp = 0; end
          else if (clrw) len = 0;
        end else if (mode == 1) begin
          if (exp_we) begin wp = (wp + 1) % CAP; len++; end
          if (len == CAP || stop) begin mode = 0; dn = 1; end
        end else begin
          if (exp_re) begin fin = (rp == len - 1); rp = (rp + 1) % CAP; end
          if (fin || stop) begin mode = 0; dn = 1; end
        end
      end
      checks++; if (STATE !== 2'(mode) || REC_LEN !== 4'(len) || FULL !== (len == CAP) ||
                    DONE !== dn || OUT_VALID !== ov) begin
        errors++; $display("FAIL rnd_state c%0d: got st=%b len=%0d full=%b done=%b ov=%b want %0d %0d %b %b %b",
                           c, STATE, REC_LEN, FULL, DONE, OUT_VALID, mode, len, (len == CAP), dn, ov);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rel = 4'b0000; iv = 1'b0; ordy = 1'b0;
    test_reset();
    test_record_stop();
    test_play_throttle();
    test_fill();
    test_empty_priority();
    test_reset_mid();
    test_stop_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog expired");
  end
endmodule
